irrigation_bcd_timer: RTL and testbench
=======================================

Name: irrigation_bcd_timer

Overview:
- Parametrised multi-digit BCD countdown timer that drives a sprinkler/drip valve for a loaded duration.
- Generalises the fixed two-digit unit/tens sprinkler counter chain:
  - N cascaded BCD digits
  - built-in tick prescaler
  - start/pause/abort control
  - loadable preset
  - explicit done/valve outputs
- Sits between the irrigation control FSM (start/abort) and the 7-segment display decoders (bcd_out).

Parameters:
DIGITS, 2, number of cascaded BCD digits (1..6); digit 0 is units.
TICK_DIV, 50000000, clk cycles per count step (>=2); e.g. 1 s at 50 MHz.
DEFAULT_PRESET, 8'h11, BCD preset, 4*DIGITS bits, applied at reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  capture load_val into the preset register (IDLE or DONE only).
load_val  input  4*DIGITS  BCD preset; any nibble >9 is clamped to 9 on capture.
start  input  1  begin countdown from the preset.
pause  input  1  level; while high in RUN, counting freezes.
abort  input  1  stop immediately, return to IDLE.
bcd_out  output  4*DIGITS  current remaining count, BCD, nibble i = digit i.
valve_on  output  1  high in RUN and PAUSED.
running  output  1  high in RUN only.
done  output  1  one-cycle pulse on reaching zero.
tick  output  1  one-cycle pulse each prescaler wrap while in RUN.

Behaviour:
- Reset (async, rst_n low):
  - preset = DEFAULT_PRESET (clamped); bcd_out = preset
  - state IDLE; prescaler = 0
  - valve_on = running = done = tick = 0
- Registered outputs: all update on the clk edge after the causing input; no combinational input-to-output paths.
- States IDLE, RUN, PAUSED, DONE. Priority each cycle: abort > start > load > pause.
- IDLE:
  - bcd_out follows preset.
  - load: preset <= clamp(load_val); bcd_out shows it next cycle.
  - start with preset != 0: RUN, prescaler cleared.
  - start with preset == 0: DONE directly, done pulses for 1 cycle, valve never opens.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. At the wrap, tick = 1 for one cycle and the count decrements by 1 (BCD borrow chain).
  - BCD borrow chain: digit i at 0 becomes 9 and borrows from digit i+1.
  - When the decrement yields all-zero: state DONE, done = 1 for that one cycle, valve_on and running fall in the same cycle.
  - pause high: PAUSED.
  - start is ignored.
  - load is ignored.
- PAUSED:
  - Prescaler and count hold; valve_on stays 1; running = 0.
  - pause low: back to RUN, prescaler resumes from the held value.
- DONE:
  - bcd_out holds 0.
  - load updates the preset but bcd_out stays 0.
  - start: reload the preset, go to RUN (or DONE again with a done pulse if preset == 0).
  - Any other input: remain.
- abort in any state:
  - IDLE next cycle; bcd_out = preset; prescaler = 0; no done pulse.
  - valve_on drops next cycle.
- Simultaneous events:
  - start+load in IDLE: start wins; the preset is not updated that cycle.
  - abort+start: abort wins.
  - pause high on the same cycle RUN is entered: RUN for that cycle, PAUSED next.
- Countdown length: exactly value(preset)*TICK_DIV cycles from the start edge to the done pulse.
- Reset mid-RUN: immediate return to reset values; the loaded preset is lost and reverts to DEFAULT_PRESET.

Test Plan:
1. Reset, DIGITS=2, TICK_DIV=4, load 8'h12, start -> bcd_out steps 12,11,10,09,...,00 every 4 cycles. The 10->09 borrow is correct. done pulses once after 48 cycles; valve_on high for exactly 48 cycles.
2. load_val 8'hAF -> preset captured as 8'h99. DIGITS=3 with preset 12'h100 -> next value 12'h099.
3. Preset 8'h05, start, assert pause for 10 cycles after 2 ticks -> bcd_out holds 03 and valve_on stays 1. After release, done arrives 10 cycles later than the unpaused run.
4. abort mid-RUN at bcd_out 07 -> next cycle IDLE, bcd_out = preset, valve_on = 0, done never pulses. start+abort together -> stays IDLE.
5. Preset 00, start -> DONE next cycle with a single done pulse and valve_on never asserted. start from DONE with preset 02 -> runs 2 ticks again.
6. rst_n low asynchronously mid-RUN (between clk edges) -> outputs clear immediately and bcd_out = DEFAULT_PRESET. After release, no tick until start.

Source files
------------

// File: rtl/irrigation_bcd_timer.sv
// rtl/irrigation_bcd_timer.sv - multi-digit BCD countdown timer driving an irrigation valve
module irrigation_bcd_timer #(
    parameter int                  DIGITS         = 2,
    parameter int                  TICK_DIV       = 50000000,
    parameter logic [4*DIGITS-1:0] DEFAULT_PRESET = 8'h11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valve_on,
    output logic                  running,
    output logic                  done,
    output logic                  tick
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    preset;
    logic [W-1:0]    preset_nxt;
    logic [W-1:0]    count;
    logic [W-1:0]    count_nxt;
    logic [W-1:0]    count_dec;
    logic [PW-1:0]   prescaler;
    logic [PW-1:0]   prescaler_nxt;
    logic            done_nxt;
    logic            tick_nxt;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign count_dec = bcd_dec(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        preset_nxt    = preset;
        count_nxt     = count;
        prescaler_nxt = prescaler;
        done_nxt      = 1'b0;
        tick_nxt      = 1'b0;
        if (abort) begin
            state_nxt     = S_IDLE;
            prescaler_nxt = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count_nxt     = preset;
                        prescaler_nxt = '0;
                        if (preset == '0) begin
                            state_nxt = S_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_RUN;
                        end
                    end else if (load) begin
                        preset_nxt = clamp_bcd(load_val);
                    end
                end
                default: begin
                    // Leaving PAUSED counts as an active cycle, so a pause of N cycles costs exactly N.
                    if (pause) begin
                        state_nxt = S_PAUSED;
                    end else begin
                        state_nxt = S_RUN;
                        if (prescaler == PS_LAST) begin
                            prescaler_nxt = '0;
                            tick_nxt      = 1'b1;
                            count_nxt     = count_dec;
                            if (count_dec == '0) begin
                                state_nxt = S_DONE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            prescaler_nxt = prescaler + PW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset    <= clamp_bcd(DEFAULT_PRESET);
            count     <= clamp_bcd(DEFAULT_PRESET);
            prescaler <= '0;
            done      <= 1'b0;
            tick      <= 1'b0;
        end else begin
            preset    <= preset_nxt;
            count     <= count_nxt;
            prescaler <= prescaler_nxt;
            done      <= done_nxt;
            tick      <= tick_nxt;
        end
    end

    always_comb begin
        valve_on = (state == S_RUN) || (state == S_PAUSED);
        running  = (state == S_RUN);
        bcd_out  = (state == S_IDLE) ? preset : count;
    end

endmodule

// File: tb/tb_irrigation_bcd_timer.sv
// tb/tb_irrigation_bcd_timer.sv - self-checking bench for irrigation_bcd_timer
module tb_irrigation_bcd_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [7:0]  load_val = '0;
    logic [7:0]  bcd_out;
    logic        valve_on, running, done, tick;

    logic        load3 = 1'b0, start3 = 1'b0, pause3 = 1'b0, abort3 = 1'b0;
    logic [11:0] load_val3 = '0;
    logic [11:0] bcd3;
    logic        valve3, running3, done3, tick3;

    always #5 clk = ~clk;

    irrigation_bcd_timer #(.DIGITS(2), .TICK_DIV(TD), .DEFAULT_PRESET(8'h11)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .abort(abort), .bcd_out(bcd_out), .valve_on(valve_on),
        .running(running), .done(done), .tick(tick)
    );

    irrigation_bcd_timer #(.DIGITS(3), .TICK_DIV(2), .DEFAULT_PRESET(12'h100)) dut3 (
        .clk(clk), .rst_n(rst_n), .load(load3), .load_val(load_val3), .start(start3),
        .pause(pause3), .abort(abort3), .bcd_out(bcd3), .valve_on(valve3),
        .running(running3), .done(done3), .tick(tick3)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal remaining time and a phase counter per tick period.
    int m_preset, m_rem, m_phase;
    bit m_active, m_paused, m_finished, m_done, m_tick;

    function automatic int clampval(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        m_preset = 11; m_rem = 0; m_phase = 0;
        m_active = 0; m_paused = 0; m_finished = 0; m_done = 0; m_tick = 0;
    endtask

    task automatic model_step(input logic ld, input logic [7:0] lv, input logic st,
                              input logic pa, input logic ab);
        m_done = 0;
        m_tick = 0;
        if (ab) begin
            m_active = 0; m_paused = 0; m_finished = 0; m_phase = 0;
        end else if (!m_active) begin
            if (st) begin
                m_phase = 0;
                m_rem = m_preset;
                if (m_preset == 0) begin
                    m_finished = 1; m_done = 1;
                end else begin
                    m_active = 1; m_paused = 0; m_finished = 0;
                end
            end else if (ld) begin
                m_preset = clampval(lv);
            end
        end else if (pa) begin
            m_paused = 1;
        end else begin
            m_paused = 0;
            m_phase++;
            if (m_phase == TD) begin
                m_phase = 0;
                m_tick = 1;
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 0; m_finished = 1; m_done = 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic ld, input logic [7:0] lv, input logic st,
                       input logic pa, input logic ab);
        load = ld; load_val = lv; start = st; pause = pa; abort = ab;
        @(posedge clk);
        model_step(ld, lv, st, pa, ab);
        #1;
    endtask

    task automatic check_model();
        check("mdl_bcd", bcd_out, to_bcd((!m_active && !m_finished) ? m_preset : m_rem));
        check("mdl_valve", valve_on, m_active);
        check("mdl_running", running, m_active && !m_paused);
        check("mdl_done", done, m_done);
        check("mdl_tick", tick, m_tick);
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       st, pa, ab;
        logic [7:0] e_bcd;
        logic       e_valve, e_run, e_done, e_tick;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic st,
                                input logic pa, input logic ab, input logic [7:0] b,
                                input logic v, input logic r, input logic d, input logic t);
        vec_t x;
        x.ld = ld; x.lv = lv; x.st = st; x.pa = pa; x.ab = ab;
        x.e_bcd = b; x.e_valve = v; x.e_run = r; x.e_done = d; x.e_tick = t;
        return x;
    endfunction

    vec_t tbl[22];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, exp_v, done_at, n_done, n_valve, n_tick;
        logic p;

        tbl[0]  = mk(1, 8'hAF, 0, 0, 0, 8'h99, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0, 0);
        tbl[2]  = mk(1, 8'h05, 1, 0, 0, 8'h12, 1, 1, 0, 0);
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 8'h12, 1, 1, 0, 0);
        tbl[4]  = mk(0, 8'h00, 1, 0, 0, 8'h12, 1, 1, 0, 0);
        tbl[5]  = mk(1, 8'h33, 0, 0, 0, 8'h12, 1, 1, 0, 0);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 8'h11, 1, 1, 0, 1);
        tbl[7]  = mk(0, 8'h00, 0, 1, 0, 8'h11, 1, 0, 0, 0);
        tbl[8]  = mk(0, 8'h00, 0, 1, 0, 8'h11, 1, 0, 0, 0);
        tbl[9]  = mk(0, 8'h00, 0, 0, 0, 8'h11, 1, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 1, 0, 1, 8'h12, 0, 0, 0, 0);
        tbl[11] = mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[12] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[14] = mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[15] = mk(0, 8'h00, 1, 0, 0, 8'h01, 1, 1, 0, 0);
        tbl[16] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 1, 0, 0);
        tbl[17] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 1, 0, 0);
        tbl[18] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 1, 0, 0);
        tbl[19] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 1);
        tbl[20] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        tbl[21] = mk(0, 8'h00, 0, 0, 1, 8'h01, 0, 0, 0, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_bcd", bcd_out, 8'h11);
        check("rst_valve", valve_on, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_bcd3", bcd3, 12'h100);
        rst_n = 1'b1;

        start3 = 1'b1;
        cyc(0, 8'h00, 0, 0, 0);
        start3 = 1'b0;
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check("d3_borrow_bcd", bcd3, 12'h099);
        check("d3_borrow_tick", tick3, 1'b1);
        abort3 = 1'b1;
        cyc(0, 8'h00, 0, 0, 0);
        abort3 = 1'b0;
        check("d3_abort_valve", valve3, 1'b0);

        foreach (tbl[i]) begin
            cyc(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].ab);
            check($sformatf("tbl%0d_bcd", i), bcd_out, tbl[i].e_bcd);
            check($sformatf("tbl%0d_valve", i), valve_on, tbl[i].e_valve);
            check($sformatf("tbl%0d_running", i), running, tbl[i].e_run);
            check($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            check($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
        end

        // Full 12-step countdown with the 10 -> 09 borrow.
        cyc(1, 8'h12, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        exp_v = 12; done_at = -1; n_done = 0; n_valve = valve_on ? 1 : 0;
        for (int j = 1; j <= 60; j++) begin
            cyc(0, 8'h00, 0, 0, 0);
            if (valve_on) n_valve++;
            if (tick) begin
                exp_v--;
                check($sformatf("cnt_step_%0d", exp_v), bcd_out, to_bcd(exp_v));
            end
            if (done) begin
                n_done++;
                done_at = j;
            end
        end
        check("cnt_done_at", done_at, 48);
        check("cnt_done_once", n_done, 1);
        check("cnt_valve_cycles", n_valve, 48);
        check("cnt_final_bcd", bcd_out, 8'h00);

        // Pause for 10 cycles after two ticks of a 5-step run.
        cyc(1, 8'h05, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        done_at = -1;
        for (int j = 1; j <= 40; j++) begin
            cyc(0, 8'h00, 0, (j >= 9 && j <= 18), 0);
            if (j == 18) begin
                check("pause_bcd", bcd_out, 8'h03);
                check("pause_valve", valve_on, 1'b1);
                check("pause_running", running, 1'b0);
            end
            if (done && done_at < 0) done_at = j;
        end
        check("pause_done_at", done_at, 30);

        // Abort mid-run at 07.
        cyc(1, 8'h09, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        for (int j = 0; j < 8; j++) cyc(0, 8'h00, 0, 0, 0);
        check("abort_pre_bcd", bcd_out, 8'h07);
        cyc(0, 8'h00, 0, 0, 1);
        check("abort_bcd", bcd_out, 8'h09);
        check("abort_valve", valve_on, 1'b0);
        check("abort_done", done, 1'b0);
        n_done = 0;
        cyc(0, 8'h00, 1, 0, 1);
        check("abort_start_valve", valve_on, 1'b0);
        for (int j = 0; j < 40; j++) begin
            cyc(0, 8'h00, 0, 0, 0);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Zero preset, then restart from DONE with 02.
        cyc(1, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        check("zero_done", done, 1'b1);
        check("zero_valve", valve_on, 1'b0);
        cyc(1, 8'h02, 0, 0, 0);
        check("zero_load_bcd", bcd_out, 8'h00);
        cyc(0, 8'h00, 1, 0, 0);
        n_tick = 0; n_done = 0;
        for (int j = 1; j <= 12; j++) begin
            cyc(0, 8'h00, 0, 0, 0);
            if (tick) n_tick++;
            if (done) begin
                n_done++;
                check("rerun_done_at", j, 8);
            end
        end
        check("rerun_ticks", n_tick, 2);
        check("rerun_dones", n_done, 1);

        // Asynchronous reset between clock edges mid-run.
        cyc(1, 8'h07, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        for (int j = 0; j < 5; j++) cyc(0, 8'h00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bcd", bcd_out, 8'h11);
        check("arst_valve", valve_on, 1'b0);
        check("arst_running", running, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_tick = 0; n_valve = 0;
        for (int j = 0; j < 12; j++) begin
            cyc(0, 8'h00, 0, 0, 0);
            if (tick) n_tick++;
            if (valve_on) n_valve++;
        end
        check("arst_no_tick", n_tick, 0);
        check("arst_no_valve", n_valve, 0);
        check("arst_bcd_after", bcd_out, 8'h11);

        // Random traffic against the reference model.
        p = 1'b0;
        for (int j = 0; j < 2500; j++) begin
            if ($urandom_range(0, 9) == 0) p = ~p;
            cyc($urandom_range(0, 99) < 10, 8'($urandom), $urandom_range(0, 99) < 6,
                p, $urandom_range(0, 99) < 2);
            check_model();
        end

        k = n_checks;
        $display("End of test - %0d assertions evaluated, %0d failures", k, n_fail);
        $finish;
    end

endmodule
